// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state codes, counter width and parameter defaults for the reset sequencer.
package reset_seq_pkg;
  localparam int unsigned SANITY_CYC_DEF    = 32'h0000AA55;
  localparam int unsigned STAGE_GAP_DEF     = 16;
  localparam int unsigned DEBOUNCE_BITS_DEF = 16;
  localparam int unsigned DDR_TIMEOUT_DEF   = 32'h00FFFFFF;
  localparam int unsigned CNT_W             = 24;
  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    COUNT    = 3'd1,
    REL_DDR  = 3'd2,
    WAIT_DDR = 3'd3,
    RUN      = 3'd4
  } state_e;
endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: 2-flop synchronizer with an optional debouncer; the output level
// only flips after 2^BITS consecutive synchronized samples disagree with it.
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned BITS    = DEBOUNCE_BITS_DEF,
  parameter bit          BYPASS  = 1'b0,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clock or negedge reset)
    if (!reset) sync_q <= {2{RST_VAL}};
    else        sync_q <= sync_d;
  generate
    if (BYPASS) begin : g_bypass
      assign q = sync_q[1];
    end else begin : g_deb
      logic [BITS-1:0] cnt_q, cnt_d;
      logic            deb_q, deb_d;
      always_comb begin
        cnt_d = (sync_q[1] == deb_q || &cnt_q) ? '0 : cnt_q + BITS'(1);
        deb_d = (sync_q[1] != deb_q && &cnt_q) ? sync_q[1] : deb_q;
      end
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          cnt_q <= '0;
          deb_q <= RST_VAL;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      assign q = deb_q;
    end
  endgenerate
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release (DDR, then MMIO, then core) after PLL lock and a
// settle period, with immediate simultaneous re-assertion on lock loss or button press.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SANITY_CYC    = SANITY_CYC_DEF,
  parameter int unsigned STAGE_GAP     = STAGE_GAP_DEF,
  parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEF,
  parameter int unsigned DDR_TIMEOUT   = DDR_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pllLocked,
  input  logic       btnReset,
  input  logic       ddrInitDone,
  output logic       resetDdr,
  output logic       resetMmio,
  output logic       resetCore,
  output logic       ddrTimeout,
  output logic [2:0] seqState
);
  localparam logic [CNT_W-1:0] SANITY_LAST = CNT_W'(SANITY_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST   = CNT_W'(DDR_TIMEOUT - 1);
  logic             lock_s, btn_s, done_s, abort;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic             rst_ddr_q, rst_ddr_d, rst_mmio_q, rst_mmio_d, rst_core_q, rst_core_d;
  reset_debounce #(.BITS(1), .BYPASS(1'b1), .RST_VAL(1'b0)) u_lock (
    .clock(clock), .reset(reset), .d(pllLocked), .q(lock_s)
  );
  reset_debounce #(.BITS(DEBOUNCE_BITS), .BYPASS(1'b0), .RST_VAL(1'b1)) u_btn (
    .clock(clock), .reset(reset), .d(btnReset), .q(btn_s)
  );
  reset_debounce #(.BITS(1), .BYPASS(1'b1), .RST_VAL(1'b0)) u_done (
    .clock(clock), .reset(reset), .d(ddrInitDone), .q(done_s)
  );
  assign abort = !lock_s || !btn_s;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tout_d  = tout_q;
    case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (!abort) begin
          state_d = COUNT;
          tout_d  = 1'b0;
        end
      end
      COUNT: if (cnt_q == SANITY_LAST) begin
        state_d = REL_DDR;
        cnt_d   = '0;
      end
      REL_DDR: if (cnt_q == GAP_LAST) begin
        state_d = WAIT_DDR;
        cnt_d   = '0;
      end
      WAIT_DDR: if (done_s || cnt_q == TOUT_LAST) begin
        state_d = RUN;
        cnt_d   = '0;
        tout_d  = !done_s;
      end
      RUN: cnt_d = '0;
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = HOLD;
      cnt_d   = '0;
    end
    // resets are registered from the next state so they move on the state-entry edge
    rst_ddr_d  = !(state_d inside {REL_DDR, WAIT_DDR, RUN});
    rst_mmio_d = !(state_d inside {WAIT_DDR, RUN});
    rst_core_d = state_d != RUN;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      tout_q     <= 1'b0;
      rst_ddr_q  <= 1'b1;
      rst_mmio_q <= 1'b1;
      rst_core_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      rst_ddr_q  <= rst_ddr_d;
      rst_mmio_q <= rst_mmio_d;
      rst_core_q <= rst_core_d;
    end
  assign resetDdr   = rst_ddr_q;
  assign resetMmio  = rst_mmio_q;
  assign resetCore  = rst_core_q;
  assign ddrTimeout = tout_q;
  assign seqState   = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven timing checks, hand-written corner sequences and a
// randomized run compared every cycle against a timestamp-based reference model.
module tb_reset_sequencer;
  localparam int S = 16, G = 4, DB = 3, T = 64;
  logic clock = 1'b0, reset = 1'b0;
  logic pllLocked = 1'b0, btnReset = 1'b1, ddrInitDone = 1'b0;
  logic resetDdr, resetMmio, resetCore, ddrTimeout;
  logic [2:0] seqState;
  int tests = 0, fails = 0;
  reset_sequencer #(.SANITY_CYC(S), .STAGE_GAP(G), .DEBOUNCE_BITS(DB), .DDR_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .pllLocked(pllLocked), .btnReset(btnReset),
    .ddrInitDone(ddrInitDone), .resetDdr(resetDdr), .resetMmio(resetMmio),
    .resetCore(resetCore), .ddrTimeout(ddrTimeout), .seqState(seqState)
  );
  always #5 clock = ~clock;
  // reference model: synchronizer delay lines, a sliding debounce window, and release times
  // derived from the edge at which the settle count began
  bit lk_h[$], dn_h[$], bt_h[$], bwin[$];
  bit m_deb, m_idle, m_tout, model_on;
  int k, m_t, m_core_t;
  function automatic logic [6:0] e(bit t, bit c, bit m, bit d, int s);
    return {t, c, m, d, 3'(s)};
  endfunction
  function automatic logic [6:0] outs();
    return {ddrTimeout, resetCore, resetMmio, resetDdr, seqState};
  endfunction
  function automatic logic [6:0] m_exp();
    int el = k - m_t;
    int st;
    if (m_idle) return e(m_tout, 1, 1, 1, 0);
    st = el < S ? 1 : el < S + G ? 2 : m_core_t < 0 ? 3 : 4;
    return e(m_tout, m_core_t < 0, el < S + G, el < S, st);
  endfunction
  task automatic model_reset();
    lk_h = '{1'b0, 1'b0};
    dn_h = '{1'b0, 1'b0};
    bt_h = '{1'b1, 1'b1};
    bwin.delete();
    for (int i = 0; i < 2 ** DB; i++) bwin.push_back(1'b1);
    m_deb = 1'b1; m_idle = 1'b1; m_tout = 1'b0; m_core_t = -1; m_t = 0;
  endtask
  task automatic model_step();
    bit lock_s, done_s, btn_s, abort, same;
    lock_s = lk_h[1]; done_s = dn_h[1]; btn_s = bt_h[1];
    abort = !lock_s || !m_deb;
    lk_h.push_front(pllLocked);   void'(lk_h.pop_back());
    dn_h.push_front(ddrInitDone); void'(dn_h.pop_back());
    bt_h.push_front(btnReset);    void'(bt_h.pop_back());
    bwin.push_front(btn_s); void'(bwin.pop_back());
    same = 1'b1;
    foreach (bwin[i]) if (bwin[i] != bwin[0]) same = 1'b0;
    if (same) m_deb = bwin[0];
    if (abort) begin
      m_idle = 1'b1; m_core_t = -1;
    end else if (m_idle) begin
      m_idle = 1'b0; m_t = k; m_tout = 1'b0; m_core_t = -1;
    end else if (m_core_t < 0 && k - 1 >= m_t + S + G && (done_s || k - (m_t + S + G) >= T)) begin
      m_core_t = k;
      if (!done_s) m_tout = 1'b1;
    end
  endtask
  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got {tout,core,mmio,ddr,st}=%b required %b", name, $time, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    k++;
    if (reset && model_on) model_step();
    #1;
    if (model_on) chk("model", outs(), m_exp());
  endtask
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk("async reset", outs(), e(0, 1, 1, 1, 0));
    model_reset();
    tick(); tick();
    reset = 1'b1;
  endtask
  typedef struct {bit lk, bt, dn; int n; logic [6:0] exp;} row_t;
  row_t tbl[20];
  int len, bounce;
  bit lk, bt;
  initial begin
    tbl[0]  = '{1, 1, 1, 18, e(0, 1, 1, 1, 1)};
    tbl[1]  = '{1, 1, 1, 1,  e(0, 1, 1, 0, 2)};
    tbl[2]  = '{1, 1, 1, 3,  e(0, 1, 1, 0, 2)};
    tbl[3]  = '{1, 1, 1, 1,  e(0, 1, 0, 0, 3)};
    tbl[4]  = '{1, 1, 1, 1,  e(0, 0, 0, 0, 4)};
    tbl[5]  = '{1, 1, 1, 10, e(0, 0, 0, 0, 4)};
    tbl[6]  = '{0, 1, 1, 2,  e(0, 0, 0, 0, 4)};
    tbl[7]  = '{0, 1, 1, 1,  e(0, 1, 1, 1, 0)};
    tbl[8]  = '{0, 1, 1, 4,  e(0, 1, 1, 1, 0)};
    tbl[9]  = '{1, 1, 1, 18, e(0, 1, 1, 1, 1)};
    tbl[10] = '{1, 1, 1, 1,  e(0, 1, 1, 0, 2)};
    tbl[11] = '{1, 1, 1, 4,  e(0, 1, 0, 0, 3)};
    tbl[12] = '{1, 1, 1, 1,  e(0, 0, 0, 0, 4)};
    tbl[13] = '{0, 1, 0, 4,  e(0, 1, 1, 1, 0)};
    tbl[14] = '{1, 1, 0, 23, e(0, 1, 0, 0, 3)};
    tbl[15] = '{1, 1, 0, 63, e(0, 1, 0, 0, 3)};
    tbl[16] = '{1, 1, 0, 1,  e(1, 0, 0, 0, 4)};
    tbl[17] = '{1, 1, 1, 5,  e(1, 0, 0, 0, 4)};
    tbl[18] = '{0, 1, 1, 4,  e(1, 1, 1, 1, 0)};
    tbl[19] = '{1, 1, 1, 3,  e(0, 1, 1, 1, 1)};
    model_on = 1'b1;
    k = 0;
    model_reset();
    tick();
    do_reset();
    foreach (tbl[i]) begin
      pllLocked = tbl[i].lk; btnReset = tbl[i].bt; ddrInitDone = tbl[i].dn;
      repeat (tbl[i].n) tick();
      chk($sformatf("table row %0d", i), outs(), tbl[i].exp);
    end
    // reset pulse in the middle of the settle count, then a full replay
    repeat (5) tick();
    chk("mid-count", outs(), e(0, 1, 1, 1, 1));
    do_reset();
    repeat (18) tick();
    chk("restart count", outs(), e(0, 1, 1, 1, 1));
    tick();
    chk("restart ddr release", outs(), e(0, 1, 1, 0, 2));
    repeat (20) tick();
    // button bounce shorter than the debounce window must not abort
    for (int c = 0; c < 50; c++) begin
      if (c % 3 == 0) btnReset = ~btnReset;
      tick();
    end
    btnReset = 1'b1;
    repeat (10) tick();
    chk("bounce no abort", outs(), e(0, 0, 0, 0, 4));
    btnReset = 1'b0;
    repeat (10) tick();
    chk("press before debounce", outs(), e(0, 0, 0, 0, 4));
    tick();
    chk("press abort", outs(), e(0, 1, 1, 1, 0));
    repeat (10) tick();
    btnReset = 1'b1;
    repeat (26) tick();
    chk("release hold", outs(), e(0, 1, 1, 1, 1));
    tick();
    chk("release ddr", outs(), e(0, 1, 1, 0, 2));
    // randomized phases of lock glitches, bouncing button and late DDR init
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(5, 90);
      lk = $urandom_range(0, 5) != 0;
      bt = $urandom_range(0, 5) != 0;
      bounce = $urandom_range(0, 3);
      for (int c = 0; c < len; c++) begin
        pllLocked = lk ^ ($urandom_range(0, 40) == 0);
        btnReset = (bounce != 0 && $urandom_range(0, bounce * 3) == 0) ? ~bt : bt;
        ddrInitDone = $urandom_range(0, len) < c;
        tick();
      end
    end
    pllLocked = 1'b1; btnReset = 1'b1; ddrInitDone = 1'b1;
    repeat (60) tick();
    chk("settled run", outs(), e(0, 0, 0, 0, 4));
    // illegal state code falls back to HOLD with every reset asserted
    model_on = 1'b0;
    @(negedge clock);
    force dut.state_q = reset_seq_pkg::state_e'(3'd6);
    #2 release dut.state_q;
    tick();
    chk("illegal state", outs(), e(0, 1, 1, 1, 0));
    model_on = 1'b1;
    do_reset();
    repeat (30) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SANITY_CYC, default 16'hAA55: post-lock settle count before any reset release.
REQ-002 Parameter STAGE_GAP, default 16: cycles between DDR reset release and MMIO reset release.
REQ-003 Parameter DEBOUNCE_BITS, default 16: button must be stable 2^DEBOUNCE_BITS cycles to change.
REQ-004 Parameter DDR_TIMEOUT, default 24'hFFFFFF: max cycles waiting for DDR init.
REQ-005 Port clock, input, 1: sole clock; all logic is posedge clock.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port pllLocked, input, 1: PLL lock, asynchronous to clock.
REQ-008 Port btnReset, input, 1: raw board reset button, active-low, asynchronous, bouncing.
REQ-009 Port ddrInitDone, input, 1: DDR controller init complete, asynchronous.
REQ-010 Port resetDdr, output, 1: active-high reset to DDR controller.
REQ-011 Port resetMmio, output, 1: active-high reset to MMIO/peripheral bus.
REQ-012 Port resetCore, output, 1: active-high reset to CPU core.
REQ-013 Port ddrTimeout, output, 1: sticky flag, DDR init timed out.
REQ-014 Port seqState, output, 3: current FSM state encoding.

Function
REQ-015 pllLocked, btnReset, ddrInitDone SHALL each pass a 2-flop synchronizer; the "_s" values are 2 cycles late.
REQ-016 btnReset_s SHALL be debounced: debounced level changes only after 2^DEBOUNCE_BITS consecutive equal samples; counter restarts on any mismatch.
REQ-017 FSM states SHALL be HOLD=0, COUNT=1, REL_DDR=2, WAIT_DDR=3, RUN=4; codes 5-7 SHALL go to HOLD.
REQ-018 HOLD: all three resets asserted, counters cleared; exit to COUNT when pllLocked_s=1 and debounced button released (high).
REQ-019 COUNT: counter increments from 0; at count SANITY_CYC-1 go to REL_DDR (COUNT lasts exactly SANITY_CYC cycles).
REQ-020 REL_DDR: resetDdr=0; after exactly STAGE_GAP cycles go to WAIT_DDR.
REQ-021 WAIT_DDR: resetDdr=0, resetMmio=0; go to RUN when ddrInitDone_s=1, or when timeout counter reaches DDR_TIMEOUT-1, in which case ddrTimeout is set.
REQ-022 RUN: all resets deasserted; remain until abort.
REQ-023 Abort: in any state, pllLocked_s=0 or debounced button pressed SHALL move to HOLD on the next edge, all resets asserted on that same edge.
REQ-024 Simultaneous lock loss and button press SHALL be a single abort; ddrInitDone_s and timeout in the same cycle SHALL not set ddrTimeout.
REQ-025 Reset outputs SHALL be registered and change on the same edge as the FSM state entry; no combinational glitching.
REQ-026 ddrTimeout SHALL clear only on entry to COUNT (new sequence) or on reset.
REQ-027 Release order SHALL always be resetDdr, then resetMmio, then resetCore; assertion is simultaneous.

Reset
REQ-028 reset low SHALL asynchronously force state HOLD, resetDdr/resetMmio/resetCore=1, ddrTimeout=0, all counters, synchronizers and debounced level to 0/released-state (debounced button = released).
REQ-029 Deassertion of reset SHALL take effect synchronously; sequencing restarts from HOLD.

Structure
REQ-030 State codes and parameter defaults SHALL live in package reset_seq_pkg.
REQ-031 Synchronizer+debouncer SHALL be sub-module reset_debounce, instanced for btnReset; lock and ddrInitDone use its synchronizer only (debounce bypass parameter).
REQ-032 Target 150-300 lines RTL.

Verification (bench params: SANITY_CYC=16, STAGE_GAP=4, DEBOUNCE_BITS=3, DDR_TIMEOUT=64)
REQ-033 pllLocked rises at edge 0, button released, ddrInitDone=1 -> resetDdr falls edge 19, resetMmio edge 23, resetCore edge 24, ddrTimeout=0.
REQ-034 ddrInitDone held 0 -> resetCore falls exactly 64 cycles after resetMmio falls; ddrTimeout=1 and sticky.
REQ-035 In RUN, pllLocked drops at edge N -> all resets =1 at edge N+3, seqState=0; relock replays REQ-033 timing.
REQ-036 btnReset toggles every 3 cycles for 50 cycles -> no abort; held low 8+ cycles -> abort, resets held until release plus debounce plus full sequence.
REQ-037 reset pulsed low mid-COUNT -> outputs =1 immediately (no clock), ddrTimeout=0, sequence restarts from HOLD.
REQ-038 Force seqState illegal (6) -> HOLD next edge, all resets asserted.
